// File: rtl/regfile_pkg.sv
// Shared definitions for the scoreboarded register file.
//   DEF_DATA_W / DEF_ADDR_W : default register width and address width
//   reg_addr_t / reg_data_t : register address / data types at the default sizes
//   ZERO_ADDR               : address of the hard-wired zero register
package regfile_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 3;

    typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
    typedef logic [DEF_DATA_W-1:0] reg_data_t;

    localparam reg_addr_t ZERO_ADDR = reg_addr_t'(0);

endpackage : regfile_pkg

// File: rtl/regfile_read_port.sv
// One combinational read port of the register file.
// It applies reset forcing, the zero-register rule, same-cycle write
// forwarding and busy forwarding to the stored value looked up by the top.
// Ports:
//   rst                      : synchronous reset; forces data and busy to 0 while high
//   rd_addr                  : read address
//   stored_data/stored_busy  : storage and scoreboard entries at rd_addr
//   wa_en/wa_addr/wa_data    : write port A (ALU), forwarding source with priority
//   wb_en/wb_addr/wb_data    : write port B (load return), forwarding source; also clears busy
//   rd_data/rd_busy          : resulting read data and busy flag
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] stored_data,
    input  logic              stored_busy,
    input  logic              wa_en,
    input  logic [ADDR_W-1:0] wa_addr,
    input  logic [DATA_W-1:0] wa_data,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_busy
);

    logic is_zero_s;
    logic hit_a_s;
    logic hit_b_s;

    assign is_zero_s = (ZERO_REG != 0) && (rd_addr == ADDR_W'(ZERO_ADDR));
    assign hit_a_s   = (BYPASS != 0) && wa_en && (wa_addr == rd_addr);
    assign hit_b_s   = (BYPASS != 0) && wb_en && (wb_addr == rd_addr);

    // Read mux: reset and zero register override everything; port A beats port B.
    always_comb begin
        rd_data = stored_data;
        rd_busy = stored_busy;
        if (rst || is_zero_s) begin
            rd_data = {DATA_W{1'b0}};
            rd_busy = 1'b0;
        end else begin
            if (hit_a_s) begin
                rd_data = wa_data;
            end else if (hit_b_s) begin
                rd_data = wb_data;
            end else begin
                rd_data = stored_data;
            end
            // A returning load makes the register usable in the same cycle.
            if (hit_b_s) begin
                rd_busy = 1'b0;
            end else begin
                rd_busy = stored_busy;
            end
        end
    end

endmodule : regfile_read_port

// File: rtl/regfile_sb.sv
// Two-read / two-write register file with write-through bypass and a
// per-register busy scoreboard for outstanding loads.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   rd1_addr/rd1_data/rd1_busy    : read port 1 (combinational)
//   rd2_addr/rd2_data/rd2_busy    : read port 2 (combinational)
//   wa_en/wa_addr/wa_data         : write port A (ALU result)
//   wb_en/wb_addr/wb_data         : write port B (load return), clears busy
//   claim_en/claim_addr           : mark a register busy when a load issues
//   busy_vec                      : registered busy bits, bit i = register i
//   wr_conflict                   : registered pulse, A and B hit the same address last cycle
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_W-1:0]    rd1_addr,
    output logic [DATA_W-1:0]    rd1_data,
    output logic                 rd1_busy,
    input  logic [ADDR_W-1:0]    rd2_addr,
    output logic [DATA_W-1:0]    rd2_data,
    output logic                 rd2_busy,
    input  logic                 wa_en,
    input  logic [ADDR_W-1:0]    wa_addr,
    input  logic [DATA_W-1:0]    wa_data,
    input  logic                 wb_en,
    input  logic [ADDR_W-1:0]    wb_addr,
    input  logic [DATA_W-1:0]    wb_data,
    input  logic                 claim_en,
    input  logic [ADDR_W-1:0]    claim_addr,
    output logic [2**ADDR_W-1:0] busy_vec,
    output logic                 wr_conflict
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic              conflict_q;
    logic              conflict_d;

    // Next-state of storage, scoreboard and conflict flag.
    always_comb begin
        busy_d     = busy_q;
        conflict_d = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if ((ZERO_REG != 0) && (i == 0)) begin
                // Zero register: no storage update, never busy.
                mem_d[i]  = {DATA_W{1'b0}};
                busy_d[i] = 1'b0;
            end else begin
                // Port A has priority on a collision; B's data is dropped.
                if (wa_en && (wa_addr == ADDR_W'(i))) begin
                    mem_d[i] = wa_data;
                end else if (wb_en && (wb_addr == ADDR_W'(i))) begin
                    mem_d[i] = wb_data;
                end else begin
                    mem_d[i] = mem_q[i];
                end
                // A new claim outranks a simultaneous load return.
                if (claim_en && (claim_addr == ADDR_W'(i))) begin
                    busy_d[i] = 1'b1;
                end else if (wb_en && (wb_addr == ADDR_W'(i))) begin
                    busy_d[i] = 1'b0;
                end else begin
                    busy_d[i] = busy_q[i];
                end
            end
        end
        // Only a real collision counts; dropped writes to the zero register do not.
        if (wa_en && wb_en && (wa_addr == wb_addr) &&
            !((ZERO_REG != 0) && (wa_addr == ADDR_W'(ZERO_ADDR)))) begin
            conflict_d = 1'b1;
        end else begin
            conflict_d = 1'b0;
        end
    end

    // State registers with synchronous reset; inputs are ignored during reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
            end
            busy_q     <= {DEPTH{1'b0}};
            conflict_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            busy_q     <= busy_d;
            conflict_q <= conflict_d;
        end
    end

    assign busy_vec    = busy_q;
    assign wr_conflict = conflict_q;

    regfile_read_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_rd1 (
        .rst         (rst),
        .rd_addr     (rd1_addr),
        .stored_data (mem_q[rd1_addr]),
        .stored_busy (busy_q[rd1_addr]),
        .wa_en       (wa_en),
        .wa_addr     (wa_addr),
        .wa_data     (wa_data),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .rd_data     (rd1_data),
        .rd_busy     (rd1_busy)
    );

    regfile_read_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_rd2 (
        .rst         (rst),
        .rd_addr     (rd2_addr),
        .stored_data (mem_q[rd2_addr]),
        .stored_busy (busy_q[rd2_addr]),
        .wa_en       (wa_en),
        .wa_addr     (wa_addr),
        .wa_data     (wa_data),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .rd_data     (rd2_data),
        .rd_busy     (rd2_busy)
    );

endmodule : regfile_sb
